// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, 16-entry branch-target LUT and the
// start/done handshake. Next PC is chosen combinationally from the current instruction.
module fetch_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [8:0]      HALT_INSTR = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr_in,
  input  logic            ctrl_branch,
  input  logic            cond_flag,
  input  logic            lut_we,
  input  logic [3:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] pc,
  output logic [8:0]      instr_out,
  output logic            instr_valid,
  output logic            busy,
  output logic            done,
  output logic [15:0]     cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0] lut_q [16];
  logic [PC_W-1:0] lut_d [16];

  logic is_halt;
  logic br_taken;

  // J (bit 0 set) always branches; BR only when the ALU condition holds.
  assign is_halt  = (instr_in == HALT_INSTR);
  assign br_taken = ctrl_branch && (instr_in[0] || cond_flag);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    cycle_cnt_d = cycle_cnt_q;
    lut_d       = lut_q;
    busy        = 1'b0;
    done        = 1'b0;
    instr_valid = 1'b0;
    instr_out   = 9'h000;

    if (lut_we) lut_d[lut_waddr] = lut_wdata;

    case (state_q)
      S_IDLE: begin
        pc_d = START_ADDR;
        if (start) begin
          state_d     = S_RUN;
          cycle_cnt_d = '0;
        end
      end
      S_RUN: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
        instr_out   = instr_in;
        if (cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
        // Halt outranks a simultaneous branch; the PC stays on the halt.
        if (is_halt)       state_d = S_DONE;
        else if (br_taken) pc_d    = lut_q[instr_in[7:4]];
        else               pc_d    = pc_q + PC_W'(1);
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d     = S_RUN;
          pc_d        = START_ADDR;
          cycle_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= START_ADDR;
      cycle_cnt_q <= '0;
      // NOTE: the LUT is deliberately reset; a branch after reset must
      // see target 0, so it is built from flops rather than a RAM macro.
      lut_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      lut_q       <= lut_d;
    end
  end

  assign pc        = pc_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural ROM and decoder branch flag
// are indexed by pc; each task drives a scenario and checks inline.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cond_flag = 1'b0;
  logic        lut_we = 1'b0;
  logic [3:0]  lut_waddr = '0;
  logic [9:0]  lut_wdata = '0;
  logic [8:0]  instr_in;
  logic        ctrl_branch;
  logic [9:0]  pc;
  logic [8:0]  instr_out;
  logic        instr_valid, busy, done;
  logic [15:0] cycle_cnt;

  logic [8:0]  rom [1024];
  logic        br_rom [1024];

  // Narrow instance used only for the PC wrap scenario.
  logic        start4 = 1'b0;
  logic [8:0]  instr_in4;
  logic [3:0]  pc4;
  logic [8:0]  instr_out4;
  logic        instr_valid4, busy4, done4;
  logic [15:0] cycle_cnt4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  always_comb instr_in    = rom[pc];
  always_comb ctrl_branch = br_rom[pc];
  always_comb instr_in4   = 9'h020 + 9'(pc4);

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .ctrl_branch(ctrl_branch), .cond_flag(cond_flag), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .pc(pc),
    .instr_out(instr_out), .instr_valid(instr_valid), .busy(busy),
    .done(done), .cycle_cnt(cycle_cnt)
  );

  fetch_unit #(.PC_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .instr_in(instr_in4),
    .ctrl_branch(1'b0), .cond_flag(1'b0), .lut_we(1'b0),
    .lut_waddr(4'd0), .lut_wdata(4'd0), .pc(pc4),
    .instr_out(instr_out4), .instr_valid(instr_valid4), .busy(busy4),
    .done(done4), .cycle_cnt(cycle_cnt4)
  );

  function automatic logic [8:0] enc_j(input logic [3:0] idx);
    return {1'b0, idx, 4'b1101};
  endfunction

  function automatic logic [8:0] enc_br(input logic [3:0] idx);
    return {1'b0, idx, 4'b1100};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom[i]    = 9'h000;
      br_rom[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic write_lut(input logic [3:0] idx, input logic [9:0] data);
    lut_we = 1'b1; lut_waddr = idx; lut_wdata = data;
    step();
    lut_we = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    tests_run++;
    if ({pc, busy, done, instr_valid, instr_out, cycle_cnt} !== {10'd0, 3'b000, 9'h000, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h busy=%b done=%b valid=%b instr=%h cnt=%0d, want all zero",
               pc, busy, done, instr_valid, instr_out, cycle_cnt);
    end
  endtask

  task automatic test_sequential();
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 9'h010 + 9'(i);
    do_reset();
    pulse_start();
    tests_run++;
    if ({busy, instr_valid, instr_out} !== {2'b11, 9'h010}) begin
      tests_failed++;
      $display("FAIL seq_first: busy=%b valid=%b instr=%h, want 1 1 010", busy, instr_valid, instr_out);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (pc !== 10'(i)) begin
        tests_failed++;
        $display("FAIL seq_pc%0d: got %h want %h", i, pc, 10'(i));
      end
      step();
    end
    tests_run++;
    if (cycle_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL seq_cnt: got %0d want 5", cycle_cnt);
    end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = enc_br(4'd3);    br_rom[0] = 1'b1;
    rom[1] = enc_br(4'd3);    br_rom[1] = 1'b1;
    rom[10'h40] = enc_j(4'd3); br_rom[10'h40] = 1'b1;
    do_reset();
    write_lut(4'd3, 10'h040);
    cond_flag = 1'b0;
    pulse_start();
    step();
    tests_run++;
    if (pc !== 10'h001) begin
      tests_failed++;
      $display("FAIL br_not_taken: got %h want 001", pc);
    end
    cond_flag = 1'b1;
    step();
    tests_run++;
    if (pc !== 10'h040) begin
      tests_failed++;
      $display("FAIL br_taken: got %h want 040", pc);
    end
    cond_flag = 1'b0;
    step();
    tests_run++;
    if (pc !== 10'h040 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL j_taken: pc=%h busy=%b want 040 1", pc, busy);
    end
  endtask

  task automatic test_halt_restart();
    clear_rom();
    rom[0] = 9'h011; rom[1] = 9'h012;
    rom[2] = HALT;   br_rom[2] = 1'b1;
    do_reset();
    pulse_start();
    step();
    step();
    tests_run++;
    if ({pc, instr_valid, instr_out, done} !== {10'd2, 1'b1, HALT, 1'b0}) begin
      tests_failed++;
      $display("FAIL halt_visible: pc=%h valid=%b instr=%h done=%b, want 002 1 1ff 0",
               pc, instr_valid, instr_out, done);
    end
    step();
    tests_run++;
    if ({done, busy, pc, instr_valid, instr_out, cycle_cnt} !== {2'b10, 10'd2, 1'b0, 9'h000, 16'd3}) begin
      tests_failed++;
      $display("FAIL halt_done: done=%b busy=%b pc=%h valid=%b instr=%h cnt=%0d, want 1 0 002 0 000 3",
               done, busy, pc, instr_valid, instr_out, cycle_cnt);
    end
    step();
    tests_run++;
    if ({done, pc, cycle_cnt} !== {1'b1, 10'd2, 16'd3}) begin
      tests_failed++;
      $display("FAIL done_hold: done=%b pc=%h cnt=%0d, want 1 002 3", done, pc, cycle_cnt);
    end
    pulse_start();
    tests_run++;
    if ({pc, done, busy, cycle_cnt} !== {10'd0, 2'b01, 16'd0}) begin
      tests_failed++;
      $display("FAIL restart: pc=%h done=%b busy=%b cnt=%0d, want 000 0 1 0", pc, done, busy, cycle_cnt);
    end
  endtask

  task automatic test_lut_collision();
    clear_rom();
    rom[0] = enc_j(4'd5);      br_rom[0] = 1'b1;
    rom[10'h10] = enc_j(4'd5); br_rom[10'h10] = 1'b1;
    do_reset();
    write_lut(4'd5, 10'h010);
    pulse_start();
    lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h020;
    step();
    lut_we = 1'b0;
    tests_run++;
    if (pc !== 10'h010) begin
      tests_failed++;
      $display("FAIL lut_old_value: got %h want 010", pc);
    end
    step();
    tests_run++;
    if (pc !== 10'h020) begin
      tests_failed++;
      $display("FAIL lut_new_value: got %h want 020", pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 15; i++) step();
    tests_run++;
    if (pc4 !== 4'hF) begin
      tests_failed++;
      $display("FAIL wrap_top: got %h want f", pc4);
    end
    step();
    tests_run++;
    if ({pc4, busy4, done4} !== {4'h0, 2'b10}) begin
      tests_failed++;
      $display("FAIL wrap_zero: pc=%h busy=%b done=%b, want 0 1 0", pc4, busy4, done4);
    end
  endtask

  task automatic test_reset_midrun();
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 9'h030;
    do_reset();
    write_lut(4'd2, 10'h033);
    pulse_start();
    for (int i = 0; i < 7; i++) step();
    tests_run++;
    if (pc !== 10'd7) begin
      tests_failed++;
      $display("FAIL midrun_pc: got %h want 007", pc);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({pc, busy, done, instr_valid, instr_out, cycle_cnt} !== {10'd0, 3'b000, 9'h000, 16'd0}) begin
      tests_failed++;
      $display("FAIL midrun_async: pc=%h busy=%b done=%b valid=%b instr=%h cnt=%0d, want all zero",
               pc, busy, done, instr_valid, instr_out, cycle_cnt);
    end
    step();
    reset = 1'b0;
    rom[0] = enc_j(4'd2); br_rom[0] = 1'b1;
    step();
    step();
    tests_run++;
    if ({pc, busy, done} !== {10'd0, 2'b00}) begin
      tests_failed++;
      $display("FAIL midrun_idle: pc=%h busy=%b done=%b, want 000 0 0", pc, busy, done);
    end
    pulse_start();
    step();
    tests_run++;
    if (pc !== 10'd0) begin
      tests_failed++;
      $display("FAIL midrun_lut_cleared: got %h want 000", pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_halt_restart();
    test_lut_collision();
    test_wrap();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
